// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and default parameters for the bytecode loader
package loader_pkg;
    typedef enum logic [2:0] {LOAD, TERM, WAIT, RUN, DONE} state_t;
    localparam logic [7:0] HALT_OP_DEFAULT = 8'hFF;
    localparam int DEPTH_DEFAULT = 1024;
endpackage

// File: rtl/loader_run_monitor.sv
// loader_run_monitor: RUN-phase completion detector (running seen, then dropped) and timeout counter
module loader_run_monitor #(
    parameter int RUN_TIMEOUT = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic cpu_running,
    output logic run_complete,
    output logic run_timeout
);
    localparam int TW = $clog2(RUN_TIMEOUT + 1);
    logic [TW-1:0] cnt;
    logic seen_running;
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt <= '0;
            seen_running <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            seen_running <= seen_running | cpu_running;
        end
    end
    // cnt holds the number of RUN cycles already completed
    assign run_complete = run && seen_running && !cpu_running;
    assign run_timeout = run && cnt == TW'(RUN_TIMEOUT - 1);
endmodule

// File: rtl/bytecode_loader.sv
// bytecode_loader: streams a program into program memory, appends the halt
// terminator, then starts the CPU and supervises its run
module bytecode_loader
    import loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter logic [7:0] HALT_OP = HALT_OP_DEFAULT,
    parameter int START_DELAY = 4,
    parameter int RUN_TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_enable,
    input  logic              cpu_running,
    output logic [ADDR_W:0]   load_count,
    output logic              done,
    output logic              overflow,
    output logic              timeout
);
    localparam int DW = $clog2(START_DELAY + 1);
    localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W + 1)'(DEPTH - 1);
    state_t state, nxt;
    logic [DW-1:0] dly;
    logic hs, full, wr, run_complete, run_timeout;
    // the final slot is reserved for the terminator, so the payload stops one short
    assign full = load_count == LAST_SLOT;
    assign in_ready = !rst && state == LOAD && !full;
    assign hs = in_valid && in_ready;
    assign wr = hs || state == TERM;
    loader_run_monitor #(.RUN_TIMEOUT(RUN_TIMEOUT)) u_mon (
        .clk(clk),
        .rst(rst),
        .run(state == RUN),
        .cpu_running(cpu_running),
        .run_complete(run_complete),
        .run_timeout(run_timeout)
    );
    always_ff @(posedge clk) begin
        state <= rst ? LOAD : nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            LOAD: nxt = (hs && in_last) || full ? TERM : LOAD;
            TERM: nxt = WAIT;
            WAIT: nxt = dly == DW'(START_DELAY) ? RUN : WAIT;
            RUN:  nxt = run_complete || run_timeout ? DONE : RUN;
            default: nxt = DONE;
        endcase
    end
    // WAIT spans START_DELAY+1 cycles so enable trails the visible terminator write by that much
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            cpu_enable <= 1'b0;
            load_count <= '0;
            done <= 1'b0;
            overflow <= 1'b0;
            timeout <= 1'b0;
            dly <= '0;
        end else begin
            mem_we <= wr;
            if (wr) begin
                mem_addr <= load_count[ADDR_W-1:0];
                mem_wdata <= state == TERM ? HALT_OP : in_data;
            end
            load_count <= load_count + (ADDR_W + 1)'(hs);
            dly <= state == WAIT ? dly + 1'b1 : '0;
            cpu_enable <= nxt == RUN;
            done <= nxt == DONE;
            overflow <= overflow || (state == LOAD && full && in_valid);
            timeout <= timeout || (run_timeout && !run_complete);
        end
    end
endmodule
